// File: rtl/trig_pkg.sv
// Shared defaults and channel-state encoding for the trigger conditioner.
package trig_pkg;

  localparam int DEF_N_TRIG         = 4;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_LOCKOUT_CYCLES = 2048;

  // Counter width for a given lockout length, never narrower than one bit.
  function automatic int lock_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int LOCK_W = lock_width(DEF_LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    LOCK     = 2'd2
  } chan_state_e;

endpackage

// File: rtl/trigger_channel.sv
// One button channel: synchroniser, re-arm-on-release FSM, lockout counter,
// registered single-cycle pulse and busy flag.
module trigger_channel
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic trigger_i,
  output logic pulse_o,
  output logic busy_o
);

  localparam int LW = lock_width(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] primed_q, primed_d;
  logic [LW-1:0]          cnt_q;
  chan_state_e            state_q;
  logic                   pulse_q;
  logic                   busy_q;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], trigger_i};
  assign s      = sync_q[SYNC_STAGES-1];

  // The synchroniser is flushed to 0 by reset, so a held button would look
  // released for a few cycles; primed_q marks when s carries a real sample.
  assign primed_d = {primed_q[SYNC_STAGES-2:0], 1'b1};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      primed_q <= '0;
      cnt_q    <= '0;
      state_q  <= WAIT_LOW;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      primed_q <= primed_d;
      pulse_q  <= 1'b0;
      case (state_q)
        WAIT_LOW: begin
          if (primed_q[SYNC_STAGES-1] && !s) begin
            state_q <= ARMED;
            busy_q  <= 1'b0;
          end
        end
        ARMED: begin
          if (s) begin
            state_q <= LOCK;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= LOCK_LOAD;
          end
        end
        LOCK: begin
          if (cnt_q == '0) begin
            state_q <= WAIT_LOW;
          end else begin
            cnt_q <= cnt_q - LW'(1);
          end
        end
        default: begin
          state_q <= WAIT_LOW;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/trigger_conditioner.sv
// Debounced push-button front end: N_TRIG independent channels producing
// single-cycle command strobes. Define TRIG_PRIORITY_EN to force Pulse one-hot.
module trigger_conditioner
  import trig_pkg::*;
#(
  parameter int N_TRIG         = DEF_N_TRIG,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_TRIG-1:0] Trigger,
  output logic [N_TRIG-1:0] Pulse,
  output logic [N_TRIG-1:0] Busy
);

  logic [N_TRIG-1:0] rawPulse;

  for (genvar i = 0; i < N_TRIG; i++) begin : g_chan
    trigger_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_chan (
      .clk_i    (Clk),
      .reset_i  (Reset),
      .trigger_i(Trigger[i]),
      .pulse_o  (rawPulse[i]),
      .busy_o   (Busy[i])
    );
  end

`ifdef TRIG_PRIORITY_EN
  // Keep only the lowest set bit; losing channels have already entered LOCK.
  assign Pulse = rawPulse & (~rawPulse + N_TRIG'(1));
`else
  assign Pulse = rawPulse;
`endif

endmodule

// File: tb/tb_trigger_conditioner.sv
// Self-checking bench for trigger_conditioner against a timing-rule model.
module tb_trigger_conditioner;

  localparam int N_TRIG  = 4;
  localparam int SYNC    = 2;
  localparam int LOCKOUT = 2048;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [N_TRIG-1:0] Trigger;
  logic [N_TRIG-1:0] Pulse;
  logic [N_TRIG-1:0] Busy;

  int checks = 0;
  int errors = 0;

  trigger_conditioner #(
    .N_TRIG        (N_TRIG),
    .SYNC_STAGES   (SYNC),
    .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Trigger(Trigger),
    .Pulse  (Pulse),
    .Busy   (Busy)
  );

  always #5 Clk = ~Clk;

  // Model: each channel ignores input up to quietUntil, then must see a
  // released button (needLow) before the next press can fire. Samples reach
  // the decision SYNC edges late; -1 marks samples not yet valid after reset.
  int                hist [N_TRIG][SYNC];
  longint            quietUntil [N_TRIG];
  bit                needLow [N_TRIG];
  longint            edgeNo = 0;
  bit                modelValid = 1'b0;
  logic [N_TRIG-1:0] expPulse, expBusy;

  always @(posedge Clk) begin
    logic [N_TRIG-1:0] raw;
    int sSeen;
    edgeNo++;
    raw = '0;
    if (Reset) begin
      modelValid = 1'b1;
      for (int c = 0; c < N_TRIG; c++) begin
        for (int k = 0; k < SYNC; k++) hist[c][k] = -1;
        needLow[c] = 1'b1;
        quietUntil[c] = -1;
      end
      expPulse = '0;
      expBusy  = '1;
    end else begin
      for (int c = 0; c < N_TRIG; c++) begin
        sSeen = hist[c][SYNC-1];
        for (int k = SYNC-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = int'(Trigger[c]);
        if (edgeNo > quietUntil[c]) begin
          if (needLow[c]) begin
            if (sSeen == 0) needLow[c] = 1'b0;
          end else if (sSeen == 1) begin
            raw[c] = 1'b1;
            quietUntil[c] = edgeNo + LOCKOUT;
            needLow[c] = 1'b1;
          end
        end
        expBusy[c] = needLow[c] || (edgeNo <= quietUntil[c]);
      end
`ifdef TRIG_PRIORITY_EN
      expPulse = '0;
      for (int c = N_TRIG-1; c >= 0; c--) if (raw[c]) expPulse = N_TRIG'(1) << c;
`else
      expPulse = raw;
`endif
    end
  end

  int                pulseCount [N_TRIG];
  int                busyCount  [N_TRIG];
  longint            lastPulseEdge [N_TRIG];
  logic [N_TRIG-1:0] firstPulseVec, firstBusyVec;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (edge %0d)", name, actual, expected, edgeNo);
    end
  endtask

  // Per-cycle comparison plus bookkeeping for the directed literal checks.
  always @(posedge Clk) begin
    #1;
    if (modelValid) begin
      checkOutput("pulse", 32'(Pulse), 32'(expPulse));
      checkOutput("busy", 32'(Busy), 32'(expBusy));
    end
    for (int c = 0; c < N_TRIG; c++) begin
      if (Pulse[c] === 1'b1) begin
        pulseCount[c]++;
        lastPulseEdge[c] = edgeNo;
      end
      if (Busy[c] === 1'b1) busyCount[c]++;
    end
    if (Pulse !== '0 && firstPulseVec === '0) begin
      firstPulseVec = Pulse;
      firstBusyVec  = Busy;
    end
  end

  task automatic clearCounts();
    for (int c = 0; c < N_TRIG; c++) begin
      pulseCount[c] = 0;
      busyCount[c] = 0;
      lastPulseEdge[c] = 0;
    end
    firstPulseVec = '0;
    firstBusyVec  = '0;
  endtask

  task automatic applyStimulus(input logic [N_TRIG-1:0] trig, input int cycles);
    Trigger = trig;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic doReset(input logic [N_TRIG-1:0] trig, input int cycles);
    Reset = 1'b1;
    applyStimulus(trig, cycles);
    Reset = 1'b0;
  endtask

  initial begin
    longint pressEdge;
    int     holdLeft [N_TRIG];
    logic [N_TRIG-1:0] level;
    Reset = 1'b1;
    Trigger = '0;
    clearCounts();
    @(negedge Clk);
    doReset('0, 3);
    applyStimulus('0, 5);

    // Single short press: 3-cycle latency, one pulse, 2049 busy cycles.
    clearCounts();
    pressEdge = edgeNo + 1;
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0000, 2200);
    checkOutput("t1_count", 32'(pulseCount[0]), 32'd1);
    checkOutput("t1_latency", 32'(lastPulseEdge[0] - pressEdge + 1), 32'd3);
    checkOutput("t1_busy", 32'(busyCount[0]), 32'd2049);
    checkOutput("t1_others", 32'(pulseCount[1] + pulseCount[2] + pulseCount[3]), 32'd0);

    // Long hold gives one pulse.
    clearCounts();
    applyStimulus(4'b0010, 4096);
    applyStimulus(4'b0000, 2200);
    checkOutput("t2_count", 32'(pulseCount[1]), 32'd1);

    // Bouncy press gives one pulse, channel re-arms afterwards.
    clearCounts();
    applyStimulus(4'b0100, 3);
    applyStimulus(4'b0000, 10);
    applyStimulus(4'b0100, 100);
    applyStimulus(4'b0000, 2200);
    checkOutput("t3_count", 32'(pulseCount[2]), 32'd1);
    checkOutput("t3_rearmed", 32'(Busy[2]), 32'd0);

    // Presses spaced 2052 apart all fire; a repeat 100 cycles later does not.
    clearCounts();
    for (int r = 0; r < 10; r++) begin
      applyStimulus(4'b1000, 1);
      applyStimulus(4'b0000, 2051);
    end
    checkOutput("t4_spaced", 32'(pulseCount[3]), 32'd10);
    clearCounts();
    applyStimulus(4'b1000, 1);
    applyStimulus(4'b0000, 99);
    applyStimulus(4'b1000, 1);
    applyStimulus(4'b0000, 2200);
    checkOutput("t4_close", 32'(pulseCount[3]), 32'd1);

    // Button held through reset must be released before it can fire.
    clearCounts();
    doReset(4'b1000, 3);
    applyStimulus(4'b1000, 50);
    checkOutput("t5_held", 32'(pulseCount[3]), 32'd0);
    applyStimulus(4'b0000, 5);
    applyStimulus(4'b1000, 1);
    applyStimulus(4'b0000, 2200);
    checkOutput("t5_after", 32'(pulseCount[3]), 32'd1);

    // Simultaneous presses on channels 0 and 2.
    clearCounts();
    applyStimulus(4'b0101, 1);
    applyStimulus(4'b0000, 2200);
`ifdef TRIG_PRIORITY_EN
    checkOutput("t6_pulse", 32'(firstPulseVec), 32'h1);
`else
    checkOutput("t6_pulse", 32'(firstPulseVec), 32'h5);
`endif
    checkOutput("t6_busy", 32'(firstBusyVec), 32'h5);

    // Random presses and bounces, with resets landing mid-activity.
    for (int c = 0; c < N_TRIG; c++) holdLeft[c] = 0;
    level = '0;
    for (int i = 0; i < 25000; i++) begin
      for (int c = 0; c < N_TRIG; c++) begin
        if (holdLeft[c] == 0) begin
          level[c] = 1'($urandom_range(0, 1));
          holdLeft[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                    : int'($urandom_range(1, 1500));
        end
        holdLeft[c]--;
      end
      Reset = (i % 9000 == 4500) || (i % 9000 == 4501);
      applyStimulus(level, 1);
    end
    Reset = 1'b0;
    applyStimulus('0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
